// File: rtl/cmag_sqrt_unit_if.sv
// Operand/result handshake bundle for cmag_sqrt_unit: complex operand in, magnitude out.
interface cmag_sqrt_unit_if #(parameter int W = 18);
   logic                  in_valid;
   logic                  in_ready;
   logic signed [W-1:0]   r;
   logic signed [W-1:0]   i;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*W-1:0]        mag_out;
   logic                  out_exact;
   logic                  busy;

   modport master (output in_valid, r, i, out_ready,
                   input  in_ready, out_valid, mag_out, out_exact, busy);
   modport slave  (input  in_valid, r, i, out_ready,
                   output in_ready, out_valid, mag_out, out_exact, busy);
endinterface

// File: rtl/cmag_sqrt_unit.sv
// Complex magnitude: floor(sqrt(r^2+i^2)) (MODE 0) or r^2+i^2 (MODE 1), one bit per cycle, MSB first.
// Result valid W+2 edges after accept (accept edge included), 2 in MODE 1; result held in DONE until out_ready.
module cmag_sqrt_unit #(
   parameter int W    = 18,
   parameter int MODE = 0
) (
   input  logic            clk,
   input  logic            reset,
   cmag_sqrt_unit_if.slave io
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

   state_t                state, state_next;
   logic signed [W-1:0]   r_q, i_q;
   logic [2*W-1:0]        sum, sq_sum;
   logic signed [2*W-1:0] r_ext, i_ext, r_sq, i_sq;
   logic [W-1:0]          root, root_step;
   logic [W+1:0]          rem;
   logic [W+3:0]          rem_sh, sub, rem_step;
   logic [CW-1:0]         cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (io.in_valid) state_next = SQUARE;
         SQUARE:  state_next = (MODE == 1) ? DONE : ROOT;
         ROOT:    if (cnt == '0) state_next = DONE;
         DONE:    if (io.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      io.in_ready  = (state == IDLE);
      io.out_valid = (state == DONE);
      io.busy      = (state != IDLE);
   end

   // Sign-extend before squaring so the product is exact in 2W bits.
   always_comb begin
      r_ext  = {{W{r_q[W-1]}}, r_q};
      i_ext  = {{W{i_q[W-1]}}, i_q};
      r_sq   = r_ext * r_ext;
      i_sq   = i_ext * i_ext;
      sq_sum = $unsigned(r_sq) + $unsigned(i_sq);
   end

   // Restoring root step: bring down the next radicand pair, try subtracting 4q+1.
   always_comb begin
      rem_sh = {rem, sum[2*W-1 -: 2]};
      sub    = {2'b00, root, 2'b01};
      if (rem_sh >= sub) begin
         rem_step  = rem_sh - sub;
         root_step = {root[W-2:0], 1'b1};
      end else begin
         rem_step  = rem_sh;
         root_step = {root[W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q        <= '0;
         i_q        <= '0;
         sum        <= '0;
         root       <= '0;
         rem        <= '0;
         cnt        <= '0;
         io.mag_out   <= '0;
         io.out_exact <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io.in_valid) begin
                  r_q <= io.r;
                  i_q <= io.i;
               end
            end
            SQUARE: begin
               sum  <= sq_sum;
               root <= '0;
               rem  <= '0;
               cnt  <= CW'(W - 1);
               if (MODE == 1) begin
                  io.mag_out   <= sq_sum;
                  io.out_exact <= 1'b1;
               end
            end
            ROOT: begin
               sum  <= {sum[2*W-3:0], 2'b00};
               root <= root_step;
               rem  <= rem_step[W+1:0];
               cnt  <= cnt - CW'(1);
               if (cnt == '0) begin
                  io.mag_out   <= {{W{1'b0}}, root_step};
                  io.out_exact <= (rem_step == '0);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
